// File: rtl/mem_bus_responder_pkg.sv
// Shared encodings for the multiplexed external bus: FSM states, bus phases, open-bus value.
// Also used by the CPU-side bus logic so both ends agree on the phase encoding.
package mem_bus_responder_pkg;

    typedef enum logic [1:0] {
        S_LO   = 2'd0,
        S_HI   = 2'd1,
        S_WAIT = 2'd2,
        S_ACC  = 2'd3
    } state_t;

    localparam logic       PH_LO    = 1'b0;
    localparam logic       PH_HI    = 1'b1;
    localparam logic [7:0] OPEN_BUS = 8'hFF;

    // Window match on the bits above the RAM index.
    function automatic logic in_window(input logic [15:0] addr,
                                       input logic [15:0] base,
                                       input int          bits);
        return (addr >> bits) == (base >> bits);
    endfunction

endpackage

// File: rtl/mem_bus_ram.sv
// Byte RAM behind the responder: 2**ADDR_BITS x 8, synchronous write, asynchronous read, no reset.
// Latency: write lands at the clock edge, read is combinational; no backpressure.
module mem_bus_ram #(
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] idx,
    input  logic [7:0]           wr_data,
    output logic [7:0]           rd_data
);

    logic [7:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wr_data;
        end
    end

    assign rd_data = mem[idx];

endmodule

// File: rtl/mem_bus_responder.sv
// Memory responder for the CPU's multiplexed bus; access 3+WAIT_STATES cycles after the low byte,
// ready held low during wait states. MEM_BUS_WR_PROTECT_EN adds write protection and wr_blocked.
module mem_bus_responder
    import mem_bus_responder_pkg::*;
#(
    parameter int          ADDR_BITS   = 8,
    parameter logic [15:0] BASE_ADDR   = 16'h0000,
    parameter int          WAIT_STATES = 0,
    parameter logic [15:0] PROT_BASE   = 16'hFF00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] addr_bus,
    input  logic       phase,
    input  logic       rw,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       ready,
    output logic       hit,
    output logic       sync_err
`ifdef MEM_BUS_WR_PROTECT_EN
    ,
    output logic       wr_blocked
`endif
);

`ifdef MEM_BUS_WR_PROTECT_EN
    localparam logic PROT_EN = 1'b1;
`else
    localparam logic PROT_EN = 1'b0;
`endif
    localparam logic [2:0] WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    state_t                 state;
    logic [7:0]             addr_lo;
    logic [7:0]             addr_hi;
    logic                   rw_q;
    logic [2:0]             wait_cnt;
    logic                   we_pend;

    logic [15:0]            acc_addr;
    logic                   acc_rw;
    logic                   acc_hit;
    logic                   acc_prot;
    logic                   enter_acc;
    logic [7:0]             rd_data;
    logic                   ram_we;

    // In S_HI the high byte is still on the bus, so decode it directly instead of the latch.
    assign acc_addr  = (state == S_HI) ? {addr_bus, addr_lo} : {addr_hi, addr_lo};
    assign acc_rw    = (state == S_HI) ? rw : rw_q;
    assign acc_hit   = in_window(acc_addr, BASE_ADDR, ADDR_BITS);
    assign acc_prot  = PROT_EN && (acc_addr >= PROT_BASE);
    assign enter_acc = ((state == S_HI) && (phase == PH_HI) && (WAIT_STATES == 0)) ||
                       ((state == S_WAIT) && (wait_cnt == 3'd0));
    assign ram_we    = (state == S_ACC) && we_pend && !rst;

    mem_bus_ram #(
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clk     (clk),
        .we      (ram_we),
        .idx     (acc_addr[ADDR_BITS-1:0]),
        .wr_data (data_in),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_LO;
            addr_lo  <= 8'h00;
            addr_hi  <= 8'h00;
            rw_q     <= 1'b1;
            wait_cnt <= 3'd0;
            we_pend  <= 1'b0;
            data_out <= 8'h00;
            data_oe  <= 1'b0;
            ready    <= 1'b1;
            hit      <= 1'b0;
            sync_err <= 1'b0;
`ifdef MEM_BUS_WR_PROTECT_EN
            wr_blocked <= 1'b0;
`endif
        end else begin
            data_oe <= 1'b0;
            hit     <= 1'b0;
            we_pend <= 1'b0;
`ifdef MEM_BUS_WR_PROTECT_EN
            wr_blocked <= 1'b0;
`endif
            if (enter_acc) begin
                hit     <= acc_hit;
                we_pend <= !acc_rw && acc_hit && !acc_prot;
`ifdef MEM_BUS_WR_PROTECT_EN
                wr_blocked <= !acc_rw && acc_hit && acc_prot;
`endif
                if (acc_rw) begin
                    data_out <= acc_hit ? rd_data : OPEN_BUS;
                    data_oe  <= acc_hit;
                end
            end

            case (state)
                S_LO: begin
                    if (phase == PH_LO) begin
                        addr_lo <= addr_bus;
                        state   <= S_HI;
                    end else begin
                        sync_err <= 1'b1;
                    end
                end
                S_HI: begin
                    if (phase == PH_HI) begin
                        addr_hi <= addr_bus;
                        rw_q    <= rw;
                        if (WAIT_STATES > 0) begin
                            state    <= S_WAIT;
                            wait_cnt <= WAIT_LOAD;
                            ready    <= 1'b0;
                        end else begin
                            state <= S_ACC;
                        end
                    end else begin
                        addr_lo <= addr_bus;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        state <= S_ACC;
                        ready <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                default: begin
                    state <= S_LO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench: instance 0 has no wait states, instance 1 has two; both use PROT_BASE 16'h00F0.
module tb_mem_bus_responder;
    import mem_bus_responder_pkg::*;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst      [2];
    logic [7:0] addr_bus [2];
    logic       phase    [2];
    logic       rw       [2];
    logic [7:0] data_in  [2];
    logic [7:0] data_out [2];
    logic       data_oe  [2];
    logic       ready    [2];
    logic       hit      [2];
    logic       sync_err [2];
`ifdef MEM_BUS_WR_PROTECT_EN
    logic       wr_blocked [2];
`endif

    int n_checks = 0;
    int n_errors = 0;

    mem_bus_responder #(.ADDR_BITS(8), .BASE_ADDR(16'h0000), .WAIT_STATES(0), .PROT_BASE(16'h00F0)) u_dut0 (
        .clk(clk), .rst(rst[0]), .addr_bus(addr_bus[0]), .phase(phase[0]), .rw(rw[0]),
        .data_in(data_in[0]), .data_out(data_out[0]), .data_oe(data_oe[0]), .ready(ready[0]),
        .hit(hit[0]), .sync_err(sync_err[0])
`ifdef MEM_BUS_WR_PROTECT_EN
        , .wr_blocked(wr_blocked[0])
`endif
    );

    mem_bus_responder #(.ADDR_BITS(8), .BASE_ADDR(16'h0000), .WAIT_STATES(2), .PROT_BASE(16'h00F0)) u_dut1 (
        .clk(clk), .rst(rst[1]), .addr_bus(addr_bus[1]), .phase(phase[1]), .rw(rw[1]),
        .data_in(data_in[1]), .data_out(data_out[1]), .data_oe(data_oe[1]), .ready(ready[1]),
        .hit(hit[1]), .sync_err(sync_err[1])
`ifdef MEM_BUS_WR_PROTECT_EN
        , .wr_blocked(wr_blocked[1])
`endif
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full bus transaction; returns what was seen in the access cycle and the cycle after.
    task automatic access(input int k, input logic [15:0] a, input logic r, input logic [7:0] wd,
                          output logic [7:0] dout, output logic oe, output logic h,
                          output logic blk, output int nwait, output logic oe_after);
        phase[k]    = PH_LO;
        addr_bus[k] = a[7:0];
        rw[k]       = r;
        @(posedge clk); #1;
        phase[k]    = PH_HI;
        addr_bus[k] = a[15:8];
        @(posedge clk); #1;
        phase[k]    = PH_LO;
        addr_bus[k] = 8'h00;
        nwait = 0;
        while (ready[k] !== 1'b1 && nwait < 16) begin
            nwait++;
            @(posedge clk); #1;
        end
        data_in[k] = wd;
        dout = data_out[k];
        oe   = data_oe[k];
        h    = hit[k];
`ifdef MEM_BUS_WR_PROTECT_EN
        blk  = wr_blocked[k];
`else
        blk  = 1'b0;
`endif
        @(posedge clk); #1;
        oe_after = data_oe[k];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic       oe, h, blk, oe2;
        int         nw;

        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; addr_bus[i] = 8'h00; phase[i] = PH_LO; rw[i] = 1'b1; data_in[i] = 8'h00;
        end
        @(posedge clk); @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_dout%0d", i), 16'(data_out[i]), 16'h0000);
            check($sformatf("rst_oe%0d", i),   16'(data_oe[i]),  16'h0000);
            check($sformatf("rst_rdy%0d", i),  16'(ready[i]),    16'h0001);
            check($sformatf("rst_hit%0d", i),  16'(hit[i]),      16'h0000);
            check($sformatf("rst_serr%0d", i), 16'(sync_err[i]), 16'h0000);
        end
        rst[0] = 1'b0; rst[1] = 1'b0;

        // Read hit, zero wait states
        access(0, 16'h0034, 1'b0, 8'hA5, d, oe, h, blk, nw, oe2);
        check("wr34_hit", 16'(h), 16'h0001);
        check("wr34_oe", 16'(oe), 16'h0000);
        access(0, 16'h0034, 1'b1, 8'h00, d, oe, h, blk, nw, oe2);
        check("rd34_dout", 16'(d), 16'h00A5);
        check("rd34_oe", 16'(oe), 16'h0001);
        check("rd34_hit", 16'(h), 16'h0001);
        check("rd34_nwait", 16'(nw), 16'h0000);
        check("rd34_oe_after", 16'(oe2), 16'h0000);

        // Write then read
        access(0, 16'h0010, 1'b0, 8'h5A, d, oe, h, blk, nw, oe2);
        access(0, 16'h0010, 1'b1, 8'h00, d, oe, h, blk, nw, oe2);
        check("rd10_dout", 16'(d), 16'h005A);

        // Miss
        access(0, 16'h0134, 1'b1, 8'h00, d, oe, h, blk, nw, oe2);
        check("miss_hit", 16'(h), 16'h0000);
        check("miss_oe", 16'(oe), 16'h0000);
        check("miss_dout", 16'(d), 16'h00FF);
        access(0, 16'h0134, 1'b0, 8'hEE, d, oe, h, blk, nw, oe2);
        check("miss_wr_hit", 16'(h), 16'h0000);
        access(0, 16'h0034, 1'b1, 8'h00, d, oe, h, blk, nw, oe2);
        check("miss_wr_kept", 16'(d), 16'h00A5);

        // Wait states on instance 1
        access(1, 16'h0040, 1'b0, 8'h12, d, oe, h, blk, nw, oe2);
        check("ws_wr_nwait", 16'(nw), 16'h0002);
        access(1, 16'h0040, 1'b1, 8'h00, d, oe, h, blk, nw, oe2);
        check("ws_rd_nwait", 16'(nw), 16'h0002);
        check("ws_rd_dout", 16'(d), 16'h0012);
        check("ws_rd_oe", 16'(oe), 16'h0001);
        check("ws_rd_oe_after", 16'(oe2), 16'h0000);

        // Sync error and low-byte restart
        access(0, 16'h0011, 1'b0, 8'h3C, d, oe, h, blk, nw, oe2);
        access(0, 16'h0022, 1'b0, 8'hC3, d, oe, h, blk, nw, oe2);
        phase[0] = PH_HI; addr_bus[0] = 8'h00;
        @(posedge clk); #1;
        check("serr_set", 16'(sync_err[0]), 16'h0001);
        phase[0] = PH_LO; addr_bus[0] = 8'h11; rw[0] = 1'b1;
        @(posedge clk); #1;
        addr_bus[0] = 8'h22;
        @(posedge clk); #1;
        phase[0] = PH_HI; addr_bus[0] = 8'h00;
        @(posedge clk); #1;
        phase[0] = PH_LO;
        check("restart_dout", 16'(data_out[0]), 16'h00C3);
        check("restart_oe", 16'(data_oe[0]), 16'h0001);
        @(posedge clk); #1;
        check("serr_sticky", 16'(sync_err[0]), 16'h0001);

        // Reset during the wait states of a write
        phase[1] = PH_LO; addr_bus[1] = 8'h40; rw[1] = 1'b0; data_in[1] = 8'h99;
        @(posedge clk); #1;
        phase[1] = PH_HI; addr_bus[1] = 8'h00;
        @(posedge clk); #1;
        phase[1] = PH_LO;
        check("abort_in_wait", 16'(ready[1]), 16'h0000);
        rst[1] = 1'b1;
        @(posedge clk); #1;
        rst[1] = 1'b0;
        check("abort_rdy", 16'(ready[1]), 16'h0001);
        check("abort_oe", 16'(data_oe[1]), 16'h0000);
        access(1, 16'h0040, 1'b1, 8'h00, d, oe, h, blk, nw, oe2);
        check("abort_ram_kept", 16'(d), 16'h0012);
        check("abort_next_oe", 16'(oe), 16'h0001);

`ifdef MEM_BUS_WR_PROTECT_EN
        begin
            logic [7:0] before;
            access(0, 16'h00F5, 1'b1, 8'h00, before, oe, h, blk, nw, oe2);
            access(0, 16'h00F5, 1'b0, 8'h77, d, oe, h, blk, nw, oe2);
            check("prot_blk", 16'(blk), 16'h0001);
            check("prot_hit", 16'(h), 16'h0001);
            access(0, 16'h00F5, 1'b1, 8'h00, d, oe, h, blk, nw, oe2);
            check("prot_kept", 16'(d), 16'(before));
            access(0, 16'h00EF, 1'b0, 8'h44, d, oe, h, blk, nw, oe2);
            check("prot_below_blk", 16'(blk), 16'h0000);
            access(0, 16'h00EF, 1'b1, 8'h00, d, oe, h, blk, nw, oe2);
            check("prot_below_rd", 16'(d), 16'h0044);
        end
`else
        access(0, 16'h00F5, 1'b0, 8'h77, d, oe, h, blk, nw, oe2);
        check("noprot_hit", 16'(h), 16'h0001);
        access(0, 16'h00F5, 1'b1, 8'h00, d, oe, h, blk, nw, oe2);
        check("noprot_rd", 16'(d), 16'h0077);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
